// File: rtl/instr_seq_pkg.sv
// ============================================================================
// instr_seq_pkg : opcode map, lane indices, state encoding and opcode decode
// Revision      : 1.0
// ============================================================================
`default_nettype none

package instr_seq_pkg;

  localparam int NUM_LANES = 4;

  localparam logic [3:0] OP_ALUI  = 4'h0;
  localparam logic [3:0] OP_ALUR  = 4'h1;
  localparam logic [3:0] OP_LOAD  = 4'h2;
  localparam logic [3:0] OP_STORE = 4'h3;
  localparam logic [3:0] OP_JMP   = 4'h4;
  localparam logic [3:0] OP_HALT  = 4'hF;

  localparam logic [1:0] LANE_ALUI = 2'd0;
  localparam logic [1:0] LANE_ALUR = 2'd1;
  localparam logic [1:0] LANE_MEM  = 2'd2;
  localparam logic [1:0] LANE_JMP  = 2'd3;

  typedef enum logic [2:0] {
    ST_FETCH  = 3'd0,
    ST_DECODE = 3'd1,
    ST_EXEC   = 3'd2,
    ST_HALT   = 3'd3,
    ST_FAULT  = 3'd4
  } seq_state_e;

  typedef enum logic [1:0] {
    CLS_EXEC    = 2'd0,
    CLS_HALT    = 2'd1,
    CLS_ILLEGAL = 2'd2
  } op_class_e;

  typedef struct packed {
    op_class_e  cls;
    logic [1:0] lane;
  } decode_t;

  // Lane is only meaningful when cls == CLS_EXEC.
  function automatic decode_t decode_opcode(input logic [3:0] op);
    decode_t d;
    d.cls  = CLS_EXEC;
    d.lane = LANE_ALUI;
    case (op)
      OP_ALUI:           d.lane = LANE_ALUI;
      OP_ALUR:           d.lane = LANE_ALUR;
      OP_LOAD, OP_STORE: d.lane = LANE_MEM;
      OP_JMP:            d.lane = LANE_JMP;
      OP_HALT:           d.cls  = CLS_HALT;
      default:           d.cls  = CLS_ILLEGAL;
    endcase
    return d;
  endfunction

endpackage

`default_nettype wire

// File: rtl/exec_watchdog.sv
// ============================================================================
// exec_watchdog : per-instruction execution timer, flags the last allowed cycle
// Revision      : 1.0
// ============================================================================
`default_nettype none

module exec_watchdog #(
  parameter int TIMEOUT = 64,
  parameter int TMR_W   = 8
) (
  input  logic clk,
  input  logic rst,
  input  logic clear,
  input  logic enable,
  output logic expired
);

  localparam logic [TMR_W-1:0] LAST = TMR_W'(TIMEOUT - 1);

  logic [TMR_W-1:0] timer;

  // Holds at LAST so a stalled enable can never wrap back into range.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      timer <= '0;
    end else if (clear) begin
      timer <= '0;
    end else if (enable && (timer != LAST)) begin
      timer <= timer + TMR_W'(1);
    end
  end

  assign expired = enable & (timer == LAST);

endmodule

`default_nettype wire

// File: rtl/instr_sequencer.sv
// ============================================================================
// instr_sequencer : fetch / decode / dispatch sequencer with halt, illegal-op
//                   and watchdog fault handling
// Revision        : 1.0
// ============================================================================
`default_nettype none

module instr_sequencer
  import instr_seq_pkg::*;
#(
  parameter int TIMEOUT = 64,
  parameter int TMR_W   = 8,
  parameter int CNT_W   = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [15:0]      memData,
  input  logic             memRdy,
  input  logic [3:0]       execDone,
  output logic             pcOutEN,
  output logic             memRead,
  output logic [15:0]      instruction,
  output logic [3:0]       start,
  output logic             busy,
  output logic             halted,
  output logic             illegal,
  output logic             timeout,
  output logic [CNT_W-1:0] retired
);

  seq_state_e state;
  seq_state_e state_next;
  decode_t    dec;
  logic [1:0] lane;
  logic       lane_done;
  logic       wd_expired;
  logic       fetch_take;
  logic       dispatch;
  logic       halt_take;
  logic       illegal_take;
  logic       exec_retire;
  logic       exec_expire;

  assign dec       = decode_opcode(instruction[15:12]);
  assign lane_done = execDone[lane];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= ST_FETCH;
    end else begin
      state <= state_next;
    end
  end

  always_comb begin
    state_next   = state;
    fetch_take   = 1'b0;
    dispatch     = 1'b0;
    halt_take    = 1'b0;
    illegal_take = 1'b0;
    exec_retire  = 1'b0;
    exec_expire  = 1'b0;
    case (state)
      ST_FETCH: begin
        if (memRdy) begin
          fetch_take = 1'b1;
          state_next = ST_DECODE;
        end
      end
      ST_DECODE: begin
        case (dec.cls)
          CLS_EXEC: begin
            dispatch   = 1'b1;
            state_next = ST_EXEC;
          end
          CLS_HALT: begin
            halt_take  = 1'b1;
            state_next = ST_HALT;
          end
          default: begin
            illegal_take = 1'b1;
            state_next   = ST_FAULT;
          end
        endcase
      end
      // Done is checked first so it wins over a same-cycle expiry.
      ST_EXEC: begin
        if (lane_done) begin
          exec_retire = 1'b1;
          state_next  = ST_FETCH;
        end else if (wd_expired) begin
          exec_expire = 1'b1;
          state_next  = ST_FAULT;
        end
      end
      ST_HALT:  state_next = ST_HALT;
      ST_FAULT: state_next = ST_FAULT;
      default:  state_next = ST_FAULT;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      instruction <= '0;
      start       <= '0;
      lane        <= LANE_ALUI;
      retired     <= '0;
      halted      <= 1'b0;
      illegal     <= 1'b0;
      timeout     <= 1'b0;
    end else begin
      start <= '0;
      if (fetch_take) begin
        instruction <= memData;
      end
      if (dispatch) begin
        lane  <= dec.lane;
        start <= 4'b0001 << dec.lane;
      end
      if (halt_take || exec_retire) begin
        retired <= retired + CNT_W'(1);
      end
      if (halt_take) begin
        halted <= 1'b1;
      end
      if (illegal_take) begin
        illegal <= 1'b1;
      end
      if (exec_expire) begin
        timeout <= 1'b1;
      end
    end
  end

  // Bus strobes are gated by rst so they drop immediately on an async reset.
  assign pcOutEN = (state == ST_FETCH) & ~rst;
  assign memRead = (state == ST_FETCH) & ~rst;
  assign busy    = (state != ST_HALT) && (state != ST_FAULT);

  exec_watchdog #(
    .TIMEOUT (TIMEOUT),
    .TMR_W   (TMR_W)
  ) u_watchdog (
    .clk     (clk),
    .rst     (rst),
    .clear   (state != ST_EXEC),
    .enable  (state == ST_EXEC),
    .expired (wd_expired)
  );

endmodule

`default_nettype wire

// File: tb/tb_instr_sequencer.sv
// ============================================================================
// tb_instr_sequencer : randomized self-checking bench with a transaction-level
//                      model of the fetch/decode/exec sequence
// Revision           : 1.0
// ============================================================================
`timescale 1ns/1ps
`default_nettype none

module tb_instr_sequencer;

  localparam int TIMEOUT = 8;
  localparam int TMR_W   = 8;
  localparam int CNT_W   = 16;

  logic             clk = 1'b0;
  logic             rst = 1'b1;
  logic [15:0]      memData = '0;
  logic             memRdy = 1'b0;
  logic [3:0]       execDone = '0;
  logic             pcOutEN;
  logic             memRead;
  logic [15:0]      instruction;
  logic [3:0]       start;
  logic             busy;
  logic             halted;
  logic             illegal;
  logic             timeout;
  logic [CNT_W-1:0] retired;

  int          n_checks = 0;
  int          n_fail   = 0;
  logic [15:0] exp_ir;
  int          exp_retired;
  bit          exp_halted;
  bit          exp_illegal;
  bit          exp_timeout;

  instr_sequencer #(
    .TIMEOUT (TIMEOUT),
    .TMR_W   (TMR_W),
    .CNT_W   (CNT_W)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .memData     (memData),
    .memRdy      (memRdy),
    .execDone    (execDone),
    .pcOutEN     (pcOutEN),
    .memRead     (memRead),
    .instruction (instruction),
    .start       (start),
    .busy        (busy),
    .halted      (halted),
    .illegal     (illegal),
    .timeout     (timeout),
    .retired     (retired)
  );

  always #5 clk = ~clk;

  initial begin
    #2_000_000;
    $display("FAIL sim_time_limit: got timeout expected completion");
    $fatal(1);
  end

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Lane index for executable opcodes, -1 for halt, -2 for illegal.
  function automatic int lane_of(input logic [15:0] w);
    case (w[15:12])
      4'h0:       return 0;
      4'h1:       return 1;
      4'h2, 4'h3: return 2;
      4'h4:       return 3;
      4'hF:       return -1;
      default:    return -2;
    endcase
  endfunction

  task automatic check_flags(input string ph);
    check_eq({ph, "_halted"},  halted,  exp_halted);
    check_eq({ph, "_illegal"}, illegal, exp_illegal);
    check_eq({ph, "_timeout"}, timeout, exp_timeout);
    check_eq({ph, "_retired"}, retired, exp_retired);
  endtask

  task automatic apply_reset();
    #2 rst = 1'b1;
    memRdy   = 1'b0;
    execDone = '0;
    exp_ir      = '0;
    exp_retired = 0;
    exp_halted  = 1'b0;
    exp_illegal = 1'b0;
    exp_timeout = 1'b0;
    #1;
    check_flags("rst");
    check_eq("rst_start",   start,       0);
    check_eq("rst_ir",      instruction, 0);
    check_eq("rst_pcOutEN", pcOutEN,     0);
    check_eq("rst_memRead", memRead,     0);
    check_eq("rst_busy",    busy,        1);
    @(posedge clk);
    #1 rst = 1'b0;
    #1;
  endtask

  // HALT / FAULT: everything quiescent and frozen whatever the inputs do.
  task automatic terminal_checks();
    for (int c = 0; c < 3; c++) begin
      check_flags("term");
      check_eq("term_busy",    busy,        0);
      check_eq("term_start",   start,       0);
      check_eq("term_pcOutEN", pcOutEN,     0);
      check_eq("term_memRead", memRead,     0);
      check_eq("term_ir",      instruction, exp_ir);
      memRdy   = 1'b1;
      memData  = 16'($urandom);
      execDone = 4'($urandom);
      tick();
    end
    memRdy   = 1'b0;
    execDone = '0;
  endtask

  // Called at the start of a FETCH cycle. done_at: EXEC cycle index of the
  // lane's done (-1 = never). abort: async reset in the first EXEC cycle.
  task automatic run_instr(input logic [15:0] word, input int rdy_delay,
                           input int done_at, input bit abort);
    int          ln;
    logic [3:0]  onehot;
    logic [3:0]  other;
    ln = lane_of(word);
    onehot = (ln >= 0) ? (4'b0001 << ln) : 4'b0000;
    for (int c = 0; c <= rdy_delay; c++) begin
      check_eq("fetch_pcOutEN", pcOutEN,     1);
      check_eq("fetch_memRead", memRead,     1);
      check_eq("fetch_busy",    busy,        1);
      check_eq("fetch_start",   start,       0);
      check_eq("fetch_ir_hold", instruction, exp_ir);
      memRdy  = (c == rdy_delay);
      memData = memRdy ? word : 16'($urandom);
      tick();
    end
    exp_ir  = word;
    memRdy  = 1'($urandom);
    memData = 16'($urandom);
    check_eq("dec_ir",      instruction, word);
    check_eq("dec_pcOutEN", pcOutEN,     0);
    check_eq("dec_memRead", memRead,     0);
    check_eq("dec_start",   start,       0);
    check_eq("dec_busy",    busy,        1);
    tick();
    if (ln == -1) begin
      exp_retired = (exp_retired + 1) % (1 << CNT_W);
      exp_halted  = 1'b1;
      terminal_checks();
      return;
    end
    if (ln == -2) begin
      exp_illegal = 1'b1;
      terminal_checks();
      return;
    end
    for (int t = 0; t < TIMEOUT; t++) begin
      check_eq("exec_start",   start,       (t == 0) ? onehot : 4'b0000);
      check_eq("exec_busy",    busy,        1);
      check_eq("exec_pcOutEN", pcOutEN,     0);
      check_eq("exec_ir",      instruction, word);
      check_flags("exec");
      if (abort && t == 0) begin
        apply_reset();
        return;
      end
      other    = 4'($urandom) & ~onehot;
      execDone = other | ((t == done_at) ? onehot : 4'b0000);
      memRdy   = 1'($urandom);
      tick();
      execDone = '0;
      memRdy   = 1'b0;
      if (t == done_at) begin
        exp_retired = (exp_retired + 1) % (1 << CNT_W);
        check_flags("retire");
        return;
      end
    end
    exp_timeout = 1'b1;
    terminal_checks();
  endtask

  function automatic logic [15:0] rand_word();
    int r;
    logic [3:0] op;
    r = $urandom_range(0, 99);
    if (r < 82)      op = 4'($urandom_range(0, 4));
    else if (r < 90) op = 4'hF;
    else             op = 4'($urandom_range(5, 14));
    return {op, 12'($urandom)};
  endfunction

  initial begin
    apply_reset();

    // Directed scenarios
    run_instr(16'h0044, 0, 3, 1'b0);
    run_instr(16'h2ABC, 3, 0, 1'b0);
    run_instr(16'h1234, 0, TIMEOUT - 1, 1'b0);
    run_instr(16'h1234, 1, -1, 1'b0);
    apply_reset();
    run_instr(16'h3001, 2, 5, 1'b0);
    run_instr(16'hF000, 0, 0, 1'b0);
    apply_reset();
    run_instr(16'h7123, 0, 0, 1'b0);
    apply_reset();
    run_instr(16'h0044, 0, 1, 1'b0);
    run_instr(16'h4000, 0, 0, 1'b1);
    run_instr(16'h0011, 1, 2, 1'b0);

    // Randomized programs, each ended by halt, fault or instruction budget
    for (int p = 0; p < 25; p++) begin
      apply_reset();
      for (int k = 0; k < 12; k++) begin
        int dly;
        int done_at;
        dly = $urandom_range(0, 3);
        done_at = ($urandom_range(0, 9) == 0) ? -1 : $urandom_range(0, TIMEOUT - 1);
        run_instr(rand_word(), dly, done_at, 1'b0);
        if (exp_halted || exp_illegal || exp_timeout) break;
      end
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

`default_nettype wire
